// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, colour bit, FSM states, start position.
package chess_pkg;

   localparam int unsigned SQ_W     = 6;
   localparam int unsigned PIECE_W  = 4;
   localparam int unsigned BOARD_W  = 256;
   localparam int unsigned COLOR_BIT = 3;

   typedef logic [PIECE_W-1:0] piece_t;
   typedef logic [SQ_W-1:0]    square_t;

   // Piece codes: bit 3 is colour (1 = black), bits [2:0] are type
   localparam piece_t EMPTY    = 4'h0;
   localparam piece_t W_PAWN   = 4'h1;
   localparam piece_t W_KNIGHT = 4'h2;
   localparam piece_t W_BISHOP = 4'h3;
   localparam piece_t W_ROOK   = 4'h4;
   localparam piece_t W_QUEEN  = 4'h5;
   localparam piece_t W_KING   = 4'h6;
   localparam piece_t B_PAWN   = 4'h9;
   localparam piece_t B_KNIGHT = 4'hA;
   localparam piece_t B_BISHOP = 4'hB;
   localparam piece_t B_ROOK   = 4'hC;
   localparam piece_t B_QUEEN  = 4'hD;
   localparam piece_t B_KING   = 4'hE;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_CHECK  = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   // Square n lives in bits [4n+3:4n]; square 0 is the least significant nibble
   localparam logic [BOARD_W-1:0] START_BOARD = {
      32'hCABEDBAC,   // squares 63..56
      32'h99999999,   // squares 55..48
      128'h0,         // squares 47..16
      32'h11111111,   // squares 15..8
      32'h42365324    // squares 7..0
   };

   // A square holds no piece when its type field is zero
   function automatic logic is_empty(input piece_t p);
      return (p[2:0] == 3'd0);
   endfunction

endpackage

// File: rtl/board_writer_if.sv
// Move request / completion bus between the game controller and board_writer.
interface board_writer_if;
   import chess_pkg::*;

   logic    move_valid;
   logic    move_ready;
   square_t move_from;
   square_t move_to;
   logic    done;
   logic    error;
   piece_t  captured;

   // Controller side issues moves and observes completion
   modport master (
      output move_valid, move_from, move_to,
      input  move_ready, done, error, captured
   );

   // Board side accepts moves and reports completion
   modport slave (
      input  move_valid, move_from, move_to,
      output move_ready, done, error, captured
   );

endinterface

// File: rtl/board_writer_square_read.sv
// 64:1 mux returning the 4-bit piece code of one square of the board.
module square_read
   import chess_pkg::*;
(
   input  logic [BOARD_W-1:0] board,
   input  square_t            sq,
   output piece_t             piece_c
);

   assign piece_c = board[{sq, 2'b00} +: PIECE_W];

endmodule

// File: rtl/board_writer.sv
// Authoritative board register: applies one move per handshake via
// fetch / check / commit. Optional build macro BOARD_PROMOTION_EN turns a
// pawn reaching the last row into a queen of the same colour.
module board_writer
   import chess_pkg::*;
#(
   parameter int CHECK_TURN = 1
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               new_game,
   board_writer_if.slave      bus,
   output logic               turn,
   output logic [BOARD_W-1:0] bigBoard
);

   state_t  state;
   state_t  state_next;

   logic    take_c;
   logic    fetch_c;
   logic    commit_c;
   logic    err_c;

   square_t from_q;
   square_t to_q;
   piece_t  src_q;
   piece_t  dst_q;
   piece_t  src_rd;
   piece_t  dst_rd;
   piece_t  piece_w;

   logic    ready_q;
   logic    done_q;
   logic    error_q;
   piece_t  captured_q;

   assign bus.move_ready = ready_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;
   assign bus.captured   = captured_q;

   // Source and destination square lookups
   square_read u_src_read (
      .board   (bigBoard),
      .sq      (from_q),
      .piece_c (src_rd)
   );

   square_read u_dst_read (
      .board   (bigBoard),
      .sq      (to_q),
      .piece_c (dst_rd)
   );

   // FSM state register; new_game aborts any move in flight
   always_ff @(posedge clk) begin
      if (reset || new_game) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and per-phase strobes
   always_comb begin
      state_next = state;
      take_c     = 1'b0;
      fetch_c    = 1'b0;
      commit_c   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.move_valid && ready_q) begin
               take_c     = 1'b1;
               state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            fetch_c    = 1'b1;
            state_next = ST_CHECK;
         end
         ST_CHECK: begin
            commit_c   = 1'b1;
            state_next = ST_COMMIT;
         end
         ST_COMMIT: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Move rejection rules and the piece actually written to the destination
   always_comb begin
      err_c = 1'b0;
      if (is_empty(src_q)) begin
         err_c = 1'b1;
      end
      if (from_q == to_q) begin
         err_c = 1'b1;
      end
      if (!is_empty(dst_q) && (dst_q[COLOR_BIT] == src_q[COLOR_BIT])) begin
         err_c = 1'b1;
      end
      if ((CHECK_TURN != 0) && (src_q[COLOR_BIT] != turn)) begin
         err_c = 1'b1;
      end

      piece_w = src_q;
`ifdef BOARD_PROMOTION_EN
      if ((src_q == W_PAWN) && (to_q[5:3] == 3'd7)) begin
         piece_w = W_QUEEN;
      end
      if ((src_q == B_PAWN) && (to_q[5:3] == 3'd0)) begin
         piece_w = B_QUEEN;
      end
`endif
   end

   // Board, turn and result registers; the board update lands as the FSM
   // enters COMMIT so it is visible in the same cycle as done
   always_ff @(posedge clk) begin
      if (reset) begin
         bigBoard   <= START_BOARD;
         turn       <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         captured_q <= EMPTY;
         from_q     <= '0;
         to_q       <= '0;
         src_q      <= EMPTY;
         dst_q      <= EMPTY;
      end else if (new_game) begin
         bigBoard   <= START_BOARD;
         turn       <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         done_q  <= commit_c;
         ready_q <= (state_next == ST_IDLE);
         if (take_c) begin
            from_q <= bus.move_from;
            to_q   <= bus.move_to;
         end
         if (fetch_c) begin
            src_q <= src_rd;
            dst_q <= dst_rd;
         end
         if (commit_c) begin
            error_q    <= err_c;
            captured_q <= dst_q;
            if (!err_c) begin
               bigBoard[{to_q, 2'b00} +: PIECE_W]   <= piece_w;
               bigBoard[{from_q, 2'b00} +: PIECE_W] <= EMPTY;
               turn                                 <= ~turn;
            end
         end
      end
   end

endmodule
